bf_program_loader: RTL
======================

# bf_program_loader

Upstream feeder for `bf_command_runner`. Accepts a Brainfuck program as an ASCII byte stream, with a valid/ready handshake and an end marker. It discards non-command characters and encodes each command into the 3-bit command code. It writes the codes sequentially into program memory from address 0, checks bracket balance, and raises `run_trigger` once a balanced, non-empty program is fully loaded.

## Interface
- `ADDR_W`, default 16: program-memory address width; matches `command_addr`.
- `DEPTH_W`, default 8: bracket-nesting counter width.
- `clk` input 1: single clock, rising edge.
- `reset_trigger_n` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `start_trigger` input 1: one-cycle pulse that begins or restarts a load.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_data` input 8: ASCII program byte.
- `in_last` input 1: qualifies the final byte of the program; sampled with `in_valid`.
- `in_ready` output 1: loader accepts a byte this cycle.
- `mem_write_trigger` output 1: one-cycle program-memory write strobe.
- `mem_addr` output ADDR_W: write address.
- `mem_command` output 3: encoded command to write.
- `program_length` output ADDR_W: number of commands written so far.
- `loaded` output 1: load finished without error; level signal.
- `run_trigger` output 1: drives `bf_command_runner.run_trigger`; level signal.
- `error` output 1: load aborted; level signal.
- `error_code` output 2: 01 = extra `]`; 10 = unclosed `[` at end; 11 = capacity overflow.

## Operation
- Encoding:
  - `+`→000, `-`→001, `[`→010, `]`→011.
  - `>`→100, `<`→101, `.`→110, `,`→111.
  - Every other byte is accepted and dropped, with no write.
- States: IDLE, LOAD, SKIP (present only with the configuration macro), DONE, ERROR.
- Reset: state IDLE. Every output is 0, including `in_ready`, `mem_addr`, `program_length` and `error_code`.
- `start_trigger` in any state:
  - next state LOAD;
  - write pointer, `program_length` and depth counter cleared;
  - `loaded`, `run_trigger`, `error` and `error_code` cleared.
- `start_trigger` mid-load discards the partial load and restarts at address 0.
- `reset_trigger_n` low has priority over `start_trigger`.
- `in_ready` is 1 only in LOAD and SKIP. A byte is accepted when `in_valid && in_ready`.
- Accepted command byte: write pointer and `program_length` increment by 1.
- Depth: `[` increments it; `]` decrements it.
- `]` with depth 0 → ERROR, code 01, no write.
- `[` with depth at 2^DEPTH_W−1 → ERROR, code 11, no write.
- Command accepted when `program_length` is 2^ADDR_W−1 → ERROR, code 11, no write. Maximum program length is 2^ADDR_W−1 commands; there is no wrap-around.
- Accepted byte with `in_last`:
  - after that byte is processed, depth ≠ 0 → ERROR, code 10;
  - otherwise → DONE, `loaded` = 1, `run_trigger` = 1 if `program_length` > 0.
- An error detected on the `in_last` byte takes precedence over the end check.
- Empty program: DONE, `loaded` = 1, `run_trigger` stays 0.
- DONE and ERROR hold until `start_trigger` or reset. `in_valid` is ignored there.

## Timing
- Byte accepted in cycle N → `mem_write_trigger`, `mem_addr` and `mem_command` valid in cycle N+1, all registered.
- In cycle N+1, `mem_addr` holds the pre-increment pointer and `program_length` holds the incremented value.
- `mem_write_trigger` is high for exactly one cycle per command. Back-to-back accepts give back-to-back writes.
- `in_last` accepted in cycle N → `loaded`/`run_trigger` or `error` asserted in cycle N+1, coincident with the final write.
- An error detected in cycle N → `error` asserted in N+1 and `in_ready` low from N+1.
- `start_trigger` in cycle N → LOAD and `in_ready` = 1 in N+1. A concurrent `in_valid` in cycle N is not accepted.
- Sustained throughput: one byte per cycle.

## Configuration
- `BF_LOADER_LINE_COMMENT_EN` defined:
  - `#` in LOAD → SKIP;
  - SKIP accepts and drops every byte until 0x0A, then returns to LOAD;
  - `in_last` in SKIP ends the load normally, with the depth check.
- Not defined: `#` is an ordinary non-command byte, and SKIP does not exist.

## Structure
- Package `bf_pkg`:
  - `bf_command_t`, a 3-bit enum of the eight codes, shared with `bf_command_runner`;
  - ASCII character constants;
  - the loader state enum;
  - the error-code localparams.
- Sub-module `bf_command_encoder`: combinational; `in_data` → {`is_command`, `bf_command_t`}.

## Test plan
- Stream `+[->+<]` with `in_last` on `]`:
  - writes at addresses 0..6 with codes 000,010,001,100,000,101,011;
  - `program_length` = 7;
  - `loaded` = `run_trigger` = 1 one cycle after the last accept.
- Stream `a+ b\n-` with gaps in `in_valid`: exactly two writes, addr 0 = 000 and addr 1 = 001, with no stalls on `in_ready`.
- Stream `]+`:
  - `error` = 1, `error_code` = 01 the cycle after `]`;
  - no write;
  - `in_ready` = 0 afterwards.
- Stream `[[]` ending with `in_last`: `error_code` = 10; three writes, at addresses 0..2.
- Pulse `start_trigger` after three commands: the next command writes addr 0; `program_length` = 1. Hold `reset_trigger_n` low mid-load: all outputs are 0 the next cycle.
- With `BF_LOADER_LINE_COMMENT_EN`, stream `+#+-\n-`: writes 000 then 001 only. Without the macro: four writes, 000,000,001,001.

Source files
------------

// File: rtl/bf_pkg.sv
// bf_pkg: shared definitions for the Brainfuck program loader and command runner.
//   bf_command_t     : 3-bit command code, shared with bf_command_runner
//   ASCII_*          : source character constants
//   loader_state_t   : loader FSM states (ST_SKIP exists only with BF_LOADER_LINE_COMMENT_EN)
//   ERR_*            : loader error codes
// Configuration macro: BF_LOADER_LINE_COMMENT_EN
package bf_pkg;

    typedef enum logic [2:0] {
        CMD_INC   = 3'b000,
        CMD_DEC   = 3'b001,
        CMD_OPEN  = 3'b010,
        CMD_CLOSE = 3'b011,
        CMD_RIGHT = 3'b100,
        CMD_LEFT  = 3'b101,
        CMD_OUT   = 3'b110,
        CMD_IN    = 3'b111
    } bf_command_t;

    localparam logic [7:0] ASCII_PLUS     = 8'h2B;
    localparam logic [7:0] ASCII_MINUS    = 8'h2D;
    localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
    localparam logic [7:0] ASCII_RBRACKET = 8'h5D;
    localparam logic [7:0] ASCII_GT       = 8'h3E;
    localparam logic [7:0] ASCII_LT       = 8'h3C;
    localparam logic [7:0] ASCII_DOT      = 8'h2E;
    localparam logic [7:0] ASCII_COMMA    = 8'h2C;
    localparam logic [7:0] ASCII_HASH     = 8'h23;
    localparam logic [7:0] ASCII_LF       = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
`ifdef BF_LOADER_LINE_COMMENT_EN
        ST_SKIP  = 3'd2,
`endif
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

    localparam logic [1:0] ERR_NONE        = 2'b00;
    localparam logic [1:0] ERR_EXTRA_CLOSE = 2'b01;
    localparam logic [1:0] ERR_UNCLOSED    = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW    = 2'b11;

endpackage

// File: rtl/bf_command_encoder.sv
// bf_command_encoder: combinational ASCII -> Brainfuck command encoder.
//   in_data    : ASCII byte
//   is_command : byte is one of the eight command characters
//   command    : encoded command (don't-care when is_command is 0)
module bf_command_encoder
    import bf_pkg::*;
(
    input  logic [7:0]  in_data,
    output logic        is_command,
    output bf_command_t command
);

    always_comb begin
        is_command = 1'b1;
        command    = CMD_INC;
        case (in_data)
            ASCII_PLUS:     command = CMD_INC;
            ASCII_MINUS:    command = CMD_DEC;
            ASCII_LBRACKET: command = CMD_OPEN;
            ASCII_RBRACKET: command = CMD_CLOSE;
            ASCII_GT:       command = CMD_RIGHT;
            ASCII_LT:       command = CMD_LEFT;
            ASCII_DOT:      command = CMD_OUT;
            ASCII_COMMA:    command = CMD_IN;
            default:        is_command = 1'b0;
        endcase
    end

endmodule

// File: rtl/bf_program_loader.sv
// bf_program_loader: streams an ASCII Brainfuck program into program memory.
//   clk, reset_trigger_n        : clock, synchronous active-low reset
//   start_trigger               : begin / restart a load
//   in_valid/in_data/in_last    : byte stream in, in_ready back-pressure
//   mem_write_trigger/mem_addr/mem_command : registered program-memory write
//   program_length              : commands written so far
//   loaded, run_trigger         : load complete (run_trigger only if non-empty)
//   error, error_code           : load aborted and why
// Configuration macro: BF_LOADER_LINE_COMMENT_EN ('#' starts a comment to end of line)
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | after reset, waiting for start_trigger
// ST_LOAD  | accepting program bytes
// ST_SKIP  | inside a '#' comment, dropping bytes until LF
// ST_DONE  | balanced program loaded, holding
// ST_ERROR | load aborted, error_code valid, holding
module bf_program_loader
    import bf_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DEPTH_W = 8
) (
    input  logic              clk,
    input  logic              reset_trigger_n,
    input  logic              start_trigger,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_write_trigger,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_command,
    output logic [ADDR_W-1:0] program_length,
    output logic              loaded,
    output logic              run_trigger,
    output logic              error,
    output logic [1:0]        error_code
);

    localparam logic [ADDR_W-1:0]  LEN_MAX   = {ADDR_W{1'b1}};
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

    loader_state_t      state, state_nxt;
    logic [DEPTH_W-1:0] depth, depth_nxt;
    logic [ADDR_W-1:0]  length_nxt, addr_nxt;
    logic [2:0]         cmd_nxt;
    logic [1:0]         code_nxt, fault_code;
    logic               wr_nxt, loaded_nxt, run_nxt, error_nxt, fault, accept;
    logic               is_command;
    bf_command_t        command;

    bf_command_encoder u_encoder (
        .in_data    (in_data),
        .is_command (is_command),
        .command    (command)
    );

`ifdef BF_LOADER_LINE_COMMENT_EN
    assign in_ready = (state == ST_LOAD) || (state == ST_SKIP);
`else
    assign in_ready = (state == ST_LOAD);
`endif
    assign accept = in_valid && in_ready;

    always_comb begin
        state_nxt  = state;
        length_nxt = program_length;
        depth_nxt  = depth;
        wr_nxt     = 1'b0;
        addr_nxt   = mem_addr;
        cmd_nxt    = mem_command;
        loaded_nxt = loaded;
        run_nxt    = run_trigger;
        error_nxt  = error;
        code_nxt   = error_code;
        fault      = 1'b0;
        fault_code = ERR_NONE;

        if (start_trigger) begin
            state_nxt  = ST_LOAD;
            length_nxt = '0;
            depth_nxt  = '0;
            loaded_nxt = 1'b0;
            run_nxt    = 1'b0;
            error_nxt  = 1'b0;
            code_nxt   = ERR_NONE;
        end else if (accept) begin
            if (state == ST_LOAD && is_command) begin
                if (command == CMD_CLOSE && depth == '0) begin
                    fault      = 1'b1;
                    fault_code = ERR_EXTRA_CLOSE;
                end else if (program_length == LEN_MAX ||
                             (command == CMD_OPEN && depth == DEPTH_MAX)) begin
                    fault      = 1'b1;
                    fault_code = ERR_OVERFLOW;
                end else begin
                    wr_nxt     = 1'b1;
                    addr_nxt   = program_length;
                    cmd_nxt    = command;
                    length_nxt = program_length + ADDR_W'(1);
                    if (command == CMD_OPEN)
                        depth_nxt = depth + DEPTH_W'(1);
                    else if (command == CMD_CLOSE)
                        depth_nxt = depth - DEPTH_W'(1);
                end
            end

            // A fault on the final byte wins over the end-of-program check.
            if (fault) begin
                state_nxt = ST_ERROR;
                error_nxt = 1'b1;
                code_nxt  = fault_code;
            end else if (in_last) begin
                if (depth_nxt != '0) begin
                    state_nxt = ST_ERROR;
                    error_nxt = 1'b1;
                    code_nxt  = ERR_UNCLOSED;
                end else begin
                    state_nxt  = ST_DONE;
                    loaded_nxt = 1'b1;
                    run_nxt    = (length_nxt != '0);
                end
            end
`ifdef BF_LOADER_LINE_COMMENT_EN
            else if (state == ST_LOAD && in_data == ASCII_HASH)
                state_nxt = ST_SKIP;
            else if (state == ST_SKIP && in_data == ASCII_LF)
                state_nxt = ST_LOAD;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_trigger_n) begin
            state             <= ST_IDLE;
            program_length    <= '0;
            depth             <= '0;
            mem_write_trigger <= 1'b0;
            mem_addr          <= '0;
            mem_command       <= '0;
            loaded            <= 1'b0;
            run_trigger       <= 1'b0;
            error             <= 1'b0;
            error_code        <= ERR_NONE;
        end else begin
            state             <= state_nxt;
            program_length    <= length_nxt;
            depth             <= depth_nxt;
            mem_write_trigger <= wr_nxt;
            mem_addr          <= addr_nxt;
            mem_command       <= cmd_nxt;
            loaded            <= loaded_nxt;
            run_trigger       <= run_nxt;
            error             <= error_nxt;
            error_code        <= code_nxt;
        end
    end

endmodule
